flash_read_ctrl: RTL and testbench

FLASH_READ_CTRL -- requirements
Module: flash_read_ctrl

---
 rtl/flash_read_ctrl.sv | 147 ++++++++++++++
 tb/tb_flash_read_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_ctrl.sv
// rtl/flash_read_ctrl.sv - pipeline-facing SPI flash read controller with one-entry hit buffer
module flash_read_ctrl #(
    parameter int GUARD_CYCLES = 11,
    parameter int TIMEOUT      = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    input  logic        inv,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        timeout_err,
    output logic [23:0] flash_addr,
    output logic        flash_button,
    input  logic        flash_read_done,
    input  logic [31:0] flash_word
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [23:0]   flash_addr_q, flash_addr_d;
    logic [23:0]   tag_addr_q, tag_addr_d;
    logic          tag_valid_q, tag_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          timeout_q, timeout_d;

    logic hit;
    logic start;
    logic guard_last;
    logic wait_last;
    logic capture;
    logic expire;

    // The buffered word is only usable while the pipeline is idle-facing.
    assign hit        = (state_q == S_IDLE) && req_valid && tag_valid_q && (req_addr == tag_addr_q);
    assign start      = (state_q == S_IDLE) && req_valid && !hit;
    assign guard_last = (guard_q == GW'(GUARD_CYCLES - 1));
    assign wait_last  = (wait_q == TW'(TIMEOUT - 1));
    // A done still high from the previous read is masked by only looking in WAIT.
    assign capture    = (state_q == S_WAIT) && flash_read_done;
    assign expire     = (state_q == S_WAIT) && !flash_read_done && wait_last;

    // State register; reset drops the button at once by forcing IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a started read always runs to DONE, even if the request is withdrawn.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: if (guard_last) state_d = S_WAIT;
            S_WAIT:  if (capture || expire) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: button is low in IDLE and DONE so each read gets a fresh rising edge.
    always_comb begin
        stall        = req_valid && !((state_q == S_DONE) || hit);
        flash_button = (state_q == S_ISSUE) || (state_q == S_WAIT);
    end

    // Datapath next-state: counters, latched address, hit buffer and timeout pulse.
    always_comb begin
        guard_d      = guard_q;
        wait_d       = wait_q;
        flash_addr_d = flash_addr_q;
        tag_addr_d   = tag_addr_q;
        tag_valid_d  = tag_valid_q;
        rdata_d      = rdata_q;
        timeout_d    = 1'b0;

        if (start) begin
            flash_addr_d = req_addr;
            guard_d      = '0;
        end

        if (state_q == S_ISSUE) begin
            guard_d = guard_q + GW'(1);
            wait_d  = '0;
        end

        if (state_q == S_WAIT) begin
            wait_d = wait_q + TW'(1);
        end

        if (capture) begin
            rdata_d     = flash_word;
            tag_addr_d  = flash_addr_q;
            tag_valid_d = 1'b1;
        end else if (expire) begin
            rdata_d     = 32'hFFFF_FFFF;
            tag_valid_d = 1'b0;
            timeout_d   = 1'b1;
        end

        // Invalidate wins over a same-cycle capture; rdata is still delivered.
        if (inv) begin
            tag_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            guard_q      <= '0;
            wait_q       <= '0;
            flash_addr_q <= '0;
            tag_addr_q   <= '0;
            tag_valid_q  <= 1'b0;
            rdata_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            guard_q      <= guard_d;
            wait_q       <= wait_d;
            flash_addr_q <= flash_addr_d;
            tag_addr_q   <= tag_addr_d;
            tag_valid_q  <= tag_valid_d;
            rdata_q      <= rdata_d;
            timeout_q    <= timeout_d;
        end
    end

    assign rdata       = rdata_q;
    assign timeout_err = timeout_q;
    assign flash_addr  = flash_addr_q;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// tb/tb_flash_read_ctrl.sv - directed self-checking bench for flash_read_ctrl
module tb_flash_read_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [23:0] req_addr;
    logic        inv;
    logic        stall;
    logic [31:0] rdata;
    logic        timeout_err;
    logic [23:0] flash_addr;
    logic        flash_button;
    logic        flash_read_done;
    logic [31:0] flash_word;

    int tests  = 0;
    int failed = 0;

    flash_read_ctrl #(
        .GUARD_CYCLES(11),
        .TIMEOUT(4096)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .inv(inv),
        .stall(stall),
        .rdata(rdata),
        .timeout_err(timeout_err),
        .flash_addr(flash_addr),
        .flash_button(flash_button),
        .flash_read_done(flash_read_done),
        .flash_word(flash_word)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int bad;
        int cnt;
        int early;

        rst             = 1'b0;
        req_valid       = 1'b0;
        req_addr        = '0;
        inv             = 1'b0;
        flash_read_done = 1'b0;
        flash_word      = '0;

        // Reset state
        adv(1);
        req_valid = 1'b1;
        #1;
        check("rst_button", flash_button, 0);
        check("rst_flash_addr", flash_addr, 0);
        check("rst_rdata", rdata, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_stall_follows_req", stall, 1);

        adv(1);
        rst       = 1'b1;
        req_valid = 1'b0;

        // Miss to 0x000100, done after 20 WAIT cycles
        adv(1);
        req_valid = 1'b1;
        req_addr  = 24'h000100;
        #1;
        check("miss_req_stall", stall, 1);
        check("miss_req_button", flash_button, 0);
        adv(1);
        #1;
        check("miss_button_rise", flash_button, 1);
        check("miss_flash_addr", flash_addr, 24'h000100);
        bad = 0;
        for (int i = 2; i < 32; i++) begin
            adv(1);
            #1;
            if (stall !== 1'b1 || flash_button !== 1'b1) bad++;
        end
        check("miss_hold_cycles", bad, 0);
        adv(1);
        flash_read_done = 1'b1;
        flash_word      = 32'hDEADBEEF;
        #1;
        check("miss_wait_stall", stall, 1);
        adv(1);
        flash_read_done = 1'b0;
        flash_word      = '0;
        #1;
        check("miss_done_stall", stall, 0);
        check("miss_done_rdata", rdata, 32'hDEADBEEF);
        check("miss_done_button", flash_button, 0);

        // Hit on the same address
        adv(1);
        #1;
        check("hit_stall", stall, 0);
        check("hit_button", flash_button, 0);
        check("hit_rdata", rdata, 32'hDEADBEEF);

        // Miss to 0x000200 with done stuck high from ISSUE entry
        adv(1);
        req_addr = 24'h000200;
        #1;
        check("stale_req_stall", stall, 1);
        adv(1);
        flash_read_done = 1'b1;
        flash_word      = 32'h12345678;
        #1;
        check("stale_button", flash_button, 1);
        check("stale_flash_addr", flash_addr, 24'h000200);
        bad = 0;
        for (int i = 37; i < 47; i++) begin
            adv(1);
            if (i == 40) req_addr = 24'h000300;
            if (i == 44) req_addr = 24'h000200;
            #1;
            if (stall !== 1'b1 || flash_addr !== 24'h000200) bad++;
        end
        check("stale_ignored_in_issue", bad, 0);
        adv(1);
        #1;
        check("stale_first_wait_stall", stall, 1);
        adv(1);
        flash_read_done = 1'b0;
        #1;
        check("stale_done_stall", stall, 0);
        check("stale_done_rdata", rdata, 32'h12345678);
        adv(1);
        req_valid = 1'b0;
        #1;
        check("idle_timeout_low", timeout_err, 0);

        // Timeout on 0x000400
        adv(1);
        req_valid = 1'b1;
        req_addr  = 24'h000400;
        #1;
        cnt   = 0;
        early = 0;
        while (stall === 1'b1 && cnt < 5000) begin
            if (timeout_err === 1'b1) early++;
            adv(1);
            #1;
            cnt++;
        end
        check("timeout_latency", cnt, 1 + 11 + 4096);
        check("timeout_no_early_pulse", early, 0);
        check("timeout_pulse", timeout_err, 1);
        check("timeout_rdata", rdata, 32'hFFFFFFFF);
        adv(1);
        #1;
        check("timeout_pulse_single", timeout_err, 0);
        check("timeout_next_misses", stall, 1);

        // Flush in WAIT and invalidate together with done
        adv(12);
        req_valid = 1'b0;
        #1;
        check("flush_stall", stall, 0);
        check("flush_button_held", flash_button, 1);
        adv(3);
        flash_read_done = 1'b1;
        flash_word      = 32'hCAFEF00D;
        inv             = 1'b1;
        #1;
        check("flush_wait_button", flash_button, 1);
        adv(1);
        flash_read_done = 1'b0;
        inv             = 1'b0;
        #1;
        check("flush_done_button", flash_button, 0);
        check("flush_done_rdata", rdata, 32'hCAFEF00D);
        adv(1);
        req_valid = 1'b1;
        req_addr  = 24'h000400;
        #1;
        check("inv_next_misses", stall, 1);

        // Complete this read so the tag is valid before the reset test
        adv(12);
        flash_read_done = 1'b1;
        flash_word      = 32'h11112222;
        adv(1);
        flash_read_done = 1'b0;
        #1;
        check("refill_rdata", rdata, 32'h11112222);
        adv(1);
        #1;
        check("refill_hit", stall, 0);

        // Reset in the middle of a WAIT
        adv(1);
        req_addr = 24'h000500;
        #1;
        check("pre_rst_miss", stall, 1);
        adv(14);
        #1;
        check("pre_rst_in_wait", flash_button, 1);
        adv(1);
        rst = 1'b0;
        #1;
        check("rst_mid_button", flash_button, 0);
        check("rst_mid_rdata", rdata, 0);
        check("rst_mid_flash_addr", flash_addr, 0);
        adv(1);
        rst      = 1'b1;
        req_addr = 24'h000400;
        #1;
        check("post_rst_miss", stall, 1);
        check("post_rst_idle_button", flash_button, 0);
        adv(1);
        #1;
        check("post_rst_issue_button", flash_button, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
